// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the stages that follow its state.
// The textbox stage selects its message from the same state encoding.
package game_pkg;

   localparam int LVL_W_DEF = 4;

   typedef enum logic [2:0] {
      GS_IDLE    = 3'd0,
      GS_PLAY    = 3'd1,
      GS_CLEAR   = 3'd2,
      GS_RESPAWN = 3'd3,
      GS_OVER    = 3'd4,
      GS_WIN     = 3'd5
   } game_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, followed by a registered
// rising-edge detector: one single-cycle pulse per press, however long it is held.
module btn_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic sync_prev_q;
   logic pulse_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q      <= 1'b0;
         sync_q      <= 1'b0;
         sync_prev_q <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         meta_q      <= btn_i;
         sync_q      <= meta_q;
         sync_prev_q <= sync_q;
         pulse_q     <= sync_q & ~sync_prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: owns state, level and lives, times pauses in frames, and drives
// freeze / level_load to the background, ship, enemies and textbox stages.
module game_controller
   import game_pkg::*;
#(
   parameter int MAX_LEVEL    = 4,
   parameter int LIVES        = 3,
   parameter int PAUSE_FRAMES = 120,
   parameter int LVL_W        = LVL_W_DEF
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             vblnk_in,
   input  logic             start_btn,
   input  logic             level_clear,
   input  logic             ship_hit,
   output logic [2:0]       state_out,
   output logic [LVL_W-1:0] level_out,
   output logic [2:0]       lives_out,
   output logic             freeze,
   output logic             level_load
);

   localparam logic [LVL_W-1:0] MAX_LVL_C = LVL_W'(MAX_LEVEL);
   localparam logic [LVL_W-1:0] LVL_ONE_C = LVL_W'(1);
   localparam logic [2:0]       LIVES_C   = 3'(LIVES);
   localparam logic [7:0]       PAUSE_C   = 8'(PAUSE_FRAMES);

   logic             start_p;
   logic             vblnk_q;
   logic             frame_tick;
   game_state_e      state_q;
   logic [LVL_W-1:0] level_q;
   logic [2:0]       lives_q;
   logic [7:0]       cnt_q;
   logic             freeze_q;
   logic             load_q;

   btn_sync_edge u_start_sync (
      .clk_i   (pclk),
      .rst_ni  (rst),
      .btn_i   (start_btn),
      .pulse_o (start_p)
   );

   always_ff @(posedge pclk) begin
      if (!rst) vblnk_q <= 1'b0;
      else      vblnk_q <= vblnk_in;
   end

   assign frame_tick = vblnk_in & ~vblnk_q;

   // freeze_q and load_q are set alongside every state_q update so they line up with it.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q  <= GS_IDLE;
         level_q  <= '0;
         lives_q  <= '0;
         cnt_q    <= '0;
         freeze_q <= 1'b1;
         load_q   <= 1'b0;
      end else begin
         load_q <= 1'b0;
         case (state_q)
            GS_IDLE: begin
               if (start_p) begin
                  state_q  <= GS_PLAY;
                  level_q  <= LVL_ONE_C;
                  lives_q  <= LIVES_C;
                  freeze_q <= 1'b0;
                  load_q   <= 1'b1;
               end
            end
            GS_PLAY: begin
               // A hit takes priority over a simultaneous clear.
               if (ship_hit) begin
                  cnt_q    <= PAUSE_C;
                  freeze_q <= 1'b1;
                  if (lives_q <= 3'd1) begin
                     state_q <= GS_OVER;
                     lives_q <= '0;
                  end else begin
                     state_q <= GS_RESPAWN;
                     lives_q <= lives_q - 3'd1;
                  end
               end else if (level_clear) begin
                  cnt_q    <= PAUSE_C;
                  freeze_q <= 1'b1;
                  state_q  <= (level_q >= MAX_LVL_C) ? GS_WIN : GS_CLEAR;
               end
            end
            GS_CLEAR, GS_RESPAWN: begin
               if (frame_tick) begin
                  if (cnt_q <= 8'd1) begin
                     state_q  <= GS_PLAY;
                     freeze_q <= 1'b0;
                     load_q   <= 1'b1;
                     if (state_q == GS_CLEAR && level_q < MAX_LVL_C)
                        level_q <= level_q + LVL_ONE_C;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end
            GS_OVER, GS_WIN: begin
               if (start_p && cnt_q == 8'd0) begin
                  state_q <= GS_IDLE;
                  level_q <= '0;
                  lives_q <= '0;
               end else if (frame_tick && cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: begin
               state_q  <= GS_IDLE;
               level_q  <= '0;
               lives_q  <= '0;
               freeze_q <= 1'b1;
            end
         endcase
      end
   end

   assign state_out  = state_q;
   assign level_out  = level_q;
   assign lives_out  = lives_q;
   assign freeze     = freeze_q;
   assign level_load = load_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboarded bench for game_controller: directed scenarios, then random
// button/event/frame traffic checked against a transaction-level game model.
module tb_game_controller;

   localparam int MAXL   = 2;
   localparam int NLIVES = 2;
   localparam int PF     = 3;

   localparam int S_IDLE = 0, S_PLAY = 1, S_CLEAR = 2, S_RESP = 3, S_OVER = 4, S_WIN = 5;

   logic       pclk = 1'b0;
   logic       rst = 1'b0;
   logic       vblnk_in = 1'b0;
   logic       start_btn = 1'b0;
   logic       level_clear = 1'b0;
   logic       ship_hit = 1'b0;
   logic [2:0] state_out;
   logic [3:0] level_out;
   logic [2:0] lives_out;
   logic       freeze;
   logic       level_load;

   always #5 pclk = ~pclk;

   game_controller #(
      .MAX_LEVEL   (MAXL),
      .LIVES       (NLIVES),
      .PAUSE_FRAMES(PF),
      .LVL_W       (4)
   ) dut (
      .pclk       (pclk),
      .rst        (rst),
      .vblnk_in   (vblnk_in),
      .start_btn  (start_btn),
      .level_clear(level_clear),
      .ship_hit   (ship_hit),
      .state_out  (state_out),
      .level_out  (level_out),
      .lives_out  (lives_out),
      .freeze     (freeze),
      .level_load (level_load)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] lvl;
      logic [2:0] lives;
      logic       ld;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;

   // Reference game model
   int m_st = S_IDLE, m_lvl = 0, m_lives = 0, m_cnt = 0;

   function automatic void check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endfunction

   task automatic move(input int st, input int lvl, input int lv);
      ev_t e;
      if (st == m_st && lvl == m_lvl && lv == m_lives) return;
      e.st    = 3'(st);
      e.lvl   = 4'(lvl);
      e.lives = 3'(lv);
      e.ld    = (st == S_PLAY && m_st != S_PLAY);
      exp_q.push_back(e);
      m_st = st; m_lvl = lvl; m_lives = lv;
   endtask

   task automatic settle();
      repeat (8) @(posedge pclk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      check("state_settled", int'(state_out), m_st);
      check("freeze_settled", int'(freeze), int'(m_st != S_PLAY));
   endtask

   task automatic press_start();
      if (m_st == S_IDLE) move(S_PLAY, 1, NLIVES);
      else if ((m_st == S_OVER || m_st == S_WIN) && m_cnt == 0) move(S_IDLE, 0, 0);
      @(negedge pclk) start_btn = 1'b1;
      repeat (10) @(negedge pclk);
      start_btn = 1'b0;
      settle();
   endtask

   task automatic game_event(input bit clr, input bit hit);
      if (m_st == S_PLAY) begin
         if (hit) begin
            m_cnt = PF;
            if (m_lives == 1) move(S_OVER, m_lvl, 0);
            else              move(S_RESP, m_lvl, m_lives - 1);
         end else if (clr) begin
            m_cnt = PF;
            move((m_lvl == MAXL) ? S_WIN : S_CLEAR, m_lvl, m_lives);
         end
      end
      @(negedge pclk);
      level_clear = clr;
      ship_hit    = hit;
      @(negedge pclk);
      level_clear = 1'b0;
      ship_hit    = 1'b0;
      settle();
   endtask

   task automatic frame();
      if (m_st == S_CLEAR || m_st == S_RESP) begin
         if (m_cnt == 1) begin
            m_cnt = 0;
            if (m_st == S_CLEAR) move(S_PLAY, (m_lvl < MAXL) ? m_lvl + 1 : MAXL, m_lives);
            else                 move(S_PLAY, m_lvl, m_lives);
         end else begin
            m_cnt--;
         end
      end else if ((m_st == S_OVER || m_st == S_WIN) && m_cnt > 0) begin
         m_cnt--;
      end
      @(negedge pclk) vblnk_in = 1'b1;
      repeat (2) @(negedge pclk);
      vblnk_in = 1'b0;
      settle();
   endtask

   task automatic pulse_reset();
      move(S_IDLE, 0, 0);
      m_cnt = 0;
      @(negedge pclk) rst = 1'b0;
      @(negedge pclk) rst = 1'b1;
      settle();
   endtask

   // Monitor: every visible change of state/level/lives is one transaction.
   logic [2:0] p_st = 3'd0;
   logic [3:0] p_lvl = 4'd0;
   logic [2:0] p_lv = 3'd0;

   always @(negedge pclk) begin
      ev_t e;
      if (mon_en) begin
         if (state_out != p_st || level_out != p_lvl || lives_out != p_lv) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_change: got state=%0d level=%0d lives=%0d, required no change",
                        state_out, level_out, lives_out);
            end else begin
               e = exp_q.pop_front();
               $display("event: state=%0d level=%0d lives=%0d freeze=%0d load=%0d",
                        state_out, level_out, lives_out, freeze, level_load);
               check("ev_state", int'(state_out), int'(e.st));
               check("ev_level", int'(level_out), int'(e.lvl));
               check("ev_lives", int'(lives_out), int'(e.lives));
               check("ev_freeze", int'(freeze), int'(e.st != 3'(S_PLAY)));
               check("ev_level_load", int'(level_load), int'(e.ld));
            end
            p_st  = state_out;
            p_lvl = level_out;
            p_lv  = lives_out;
         end else if (level_load) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_level_load: got 1, required 0 (state=%0d)", state_out);
         end
      end
   end

   initial begin
      int unsigned r;
      repeat (3) @(negedge pclk);
      check("rst_state", int'(state_out), S_IDLE);
      check("rst_level", int'(level_out), 0);
      check("rst_lives", int'(lives_out), 0);
      check("rst_freeze", int'(freeze), 1);
      check("rst_level_load", int'(level_load), 0);
      mon_en = 1'b1;
      rst    = 1'b1;
      settle();

      // Start, clear level 1, wait out the pause
      press_start();
      game_event(1'b1, 1'b0);
      repeat (PF) frame();
      // Clear last level -> WIN; early start ignored, late start returns to IDLE
      game_event(1'b1, 1'b0);
      frame();
      press_start();
      repeat (PF - 1) frame();
      press_start();
      // Two hits: respawn, then game over
      press_start();
      game_event(1'b0, 1'b1);
      repeat (PF) frame();
      game_event(1'b0, 1'b1);
      repeat (PF) frame();
      press_start();
      // Simultaneous hit and clear
      press_start();
      game_event(1'b1, 1'b1);
      repeat (PF) frame();
      // Reset in the middle of a CLEAR pause
      game_event(1'b1, 1'b0);
      frame();
      pulse_reset();

      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 19);
         if (r < 4)       press_start();
         else if (r < 8)  game_event(1'b1, 1'b0);
         else if (r < 11) game_event(1'b0, 1'b1);
         else if (r < 12) game_event(1'b1, 1'b1);
         else if (r < 19) frame();
         else             pulse_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
